fetch_unit: RTL and testbench

Instruction fetch stage for the 16-bit processor. It owns the program counter, runs a request/ready handshake against instruction memory, and presents each fetched 16-bit word with its address to the downstream instruction register. Branch redirects and decode stalls are handled here; the downstream register simply loads `instr` when `instr_valid` is high and `stall` is low.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the PC, handshakes with
//             instruction memory, and handles branch redirects and stalls.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [15:0] fetch_pc_q,   fetch_pc_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic [15:0] instr_q,      instr_d;
    logic [15:0] instr_pc_q,   instr_pc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= 16'h0000;
            instr_q      <= 16'h0000;
            instr_pc_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;

        if (branch_taken) begin
            fetch_pc_d = branch_target;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    if (!mem_ready) begin
                        // Request in flight cannot be withdrawn; keep its address.
                        drain_addr_d = fetch_pc_q;
                        state_d      = DRAIN;
                    end
                end else if (mem_ready) begin
                    instr_d    = mem_rdata;
                    instr_pc_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    state_d    = HOLD;
                end
            end
            DRAIN: begin
                // Completion always ends the drain, even alongside a new branch.
                if (mem_ready) begin
                    state_d = en ? REQ : IDLE;
                end
            end
            HOLD: begin
                if (branch_taken || !stall) begin
                    state_d = en ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req     = (state_q == REQ) || (state_q == DRAIN);
    assign mem_addr    = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed vector bench for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        en, stall, branch_taken, mem_ready;
    logic [15:0] branch_target;
    logic        mem_req, instr_valid;
    logic [15:0] mem_addr, mem_rdata, instr, instr_pc;

    logic        w_en, w_mem_ready;
    logic        w_mem_req, w_instr_valid;
    logic [15:0] w_mem_addr, w_mem_rdata, w_instr, w_instr_pc;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .en(en), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .reset(reset), .en(w_en), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(16'h0000),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ready(w_mem_ready),
        .mem_rdata(w_mem_rdata), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_valid(w_instr_valid)
    );

    // Memory model: each word holds its address xor a fixed pattern.
    assign mem_rdata   = mem_addr   ^ 16'hA5A5;
    assign w_mem_rdata = w_mem_addr ^ 16'hA5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        rdy;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic i_en, input logic i_st, input logic i_br,
                       input logic [15:0] i_tgt, input logic i_rdy,
                       input logic x_req, input logic [15:0] x_addr,
                       input logic x_val, input logic [15:0] x_instr,
                       input logic [15:0] x_pc);
        vec_t v;
        v.en = i_en; v.stall = i_st; v.br = i_br; v.tgt = i_tgt; v.rdy = i_rdy;
        v.e_req = x_req; v.e_addr = x_addr; v.e_valid = x_val;
        v.e_instr = x_instr; v.e_pc = x_pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] wpc;

    initial begin
        reset = 1'b1;
        en = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        mem_ready = 1'b0; w_en = 1'b0; w_mem_ready = 1'b0;

        //   en st br tgt      rdy  req addr     val instr    pc
        add(1, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0000, 16'h0000); // 0 IDLE
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0000, 0, 16'h0000, 16'h0000); // 1 REQ
        add(1, 0, 0, 16'h0000, 1,  0, 16'h0001, 1, 16'hA5A5, 16'h0000); // 2 HOLD
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0001, 0, 16'hA5A5, 16'h0000);
        add(1, 0, 0, 16'h0000, 1,  0, 16'h0002, 1, 16'hA5A4, 16'h0001);
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0002, 0, 16'hA5A4, 16'h0001);
        add(1, 0, 0, 16'h0000, 1,  0, 16'h0003, 1, 16'hA5A7, 16'h0002);
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0003, 0, 16'hA5A7, 16'h0002);
        add(1, 0, 0, 16'h0000, 0,  0, 16'h0004, 1, 16'hA5A6, 16'h0003); // 8 HOLD
        add(1, 0, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'hA5A6, 16'h0003); // wait states
        add(1, 0, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'hA5A6, 16'h0003);
        add(1, 0, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'hA5A6, 16'h0003);
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0004, 0, 16'hA5A6, 16'h0003);
        add(1, 1, 0, 16'h0000, 0,  0, 16'h0005, 1, 16'hA5A1, 16'h0004); // 13 stall x4
        add(1, 1, 0, 16'h0000, 0,  0, 16'h0005, 1, 16'hA5A1, 16'h0004);
        add(1, 1, 0, 16'h0000, 0,  0, 16'h0005, 1, 16'hA5A1, 16'h0004);
        add(1, 1, 0, 16'h0000, 0,  0, 16'h0005, 1, 16'hA5A1, 16'h0004);
        add(1, 0, 0, 16'h0000, 0,  0, 16'h0005, 1, 16'hA5A1, 16'h0004);
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0005, 0, 16'hA5A1, 16'h0004);
        add(1, 1, 1, 16'h0100, 0,  0, 16'h0006, 1, 16'hA5A0, 16'h0005); // 19 branch in HOLD
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0100, 0, 16'hA5A0, 16'h0005);
        add(1, 0, 0, 16'h0000, 0,  0, 16'h0101, 1, 16'hA4A5, 16'h0100);
        add(1, 0, 1, 16'h0200, 0,  1, 16'h0101, 0, 16'hA4A5, 16'h0100); // 22 branch in REQ
        add(1, 0, 0, 16'h0000, 0,  1, 16'h0101, 0, 16'hA4A5, 16'h0100); // DRAIN
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0101, 0, 16'hA4A5, 16'h0100);
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0200, 0, 16'hA4A5, 16'h0100);
        add(1, 0, 0, 16'h0000, 0,  0, 16'h0201, 1, 16'hA7A5, 16'h0200);
        add(1, 0, 1, 16'h0300, 1,  1, 16'h0201, 0, 16'hA7A5, 16'h0200); // 27 branch+ready
        add(1, 0, 0, 16'h0000, 1,  1, 16'h0300, 0, 16'hA7A5, 16'h0200);
        add(0, 0, 0, 16'h0000, 0,  0, 16'h0301, 1, 16'hA6A5, 16'h0300);
        add(0, 0, 1, 16'h0400, 0,  0, 16'h0301, 0, 16'hA6A5, 16'h0300); // 30 branch in IDLE
        add(1, 0, 0, 16'h0000, 0,  0, 16'h0400, 0, 16'hA6A5, 16'h0300);
        add(0, 0, 0, 16'h0000, 0,  1, 16'h0400, 0, 16'hA6A5, 16'h0300); // en low in REQ
        add(0, 0, 0, 16'h0000, 1,  1, 16'h0400, 0, 16'hA6A5, 16'h0300);
        add(0, 0, 0, 16'h0000, 0,  0, 16'h0401, 1, 16'hA1A5, 16'h0400);
        add(0, 0, 0, 16'h0000, 0,  0, 16'h0401, 0, 16'hA1A5, 16'h0400);

        #1;
        check("rst_req",   {15'd0, mem_req},     16'd0);
        check("rst_addr",  mem_addr,             16'h0000);
        check("rst_valid", {15'd0, instr_valid}, 16'd0);
        check("rst_instr", instr,                16'h0000);
        check("rst_pc",    instr_pc,             16'h0000);
        check("rst_waddr", w_mem_addr,           16'hFFFE);
        tick();
        reset = 1'b0;

        foreach (vecs[i]) begin
            en            = vecs[i].en;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            mem_ready     = vecs[i].rdy;
            check($sformatf("v%0d_req", i),   {15'd0, mem_req},     {15'd0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i),  mem_addr,             vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, vecs[i].e_valid});
            check($sformatf("v%0d_instr", i), instr,                vecs[i].e_instr);
            check($sformatf("v%0d_pc", i),    instr_pc,             vecs[i].e_pc);
            tick();
        end

        // Asynchronous reset while draining a redirected request.
        en = 1'b1; stall = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        tick();
        check("mr_req_before", {15'd0, mem_req}, 16'd1);
        check("mr_addr_before", mem_addr, 16'h0401);
        branch_taken = 1'b1; branch_target = 16'h0500;
        tick();
        branch_taken = 1'b0;
        check("mr_drain_req", {15'd0, mem_req}, 16'd1);
        check("mr_drain_addr", mem_addr, 16'h0401);
        #2;
        reset = 1'b1;
        #1;
        check("mr_req_async",   {15'd0, mem_req},     16'd0);
        check("mr_valid_async", {15'd0, instr_valid}, 16'd0);
        check("mr_addr_async",  mem_addr,             16'h0000);
        #2;
        reset = 1'b0;
        tick();
        check("mr_req_after",  {15'd0, mem_req}, 16'd1);
        check("mr_addr_after", mem_addr,         16'h0000);
        mem_ready = 1'b1;
        tick();
        check("mr_valid_after", {15'd0, instr_valid}, 16'd1);
        check("mr_pc_after",    instr_pc,             16'h0000);
        check("mr_instr_after", instr,                16'hA5A5);
        en = 1'b0; mem_ready = 1'b0;

        // PC wrap-around from RESET_PC = FFFE.
        w_en = 1'b1; w_mem_ready = 1'b1;
        wpc = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("wrap%0d_req", k),  {15'd0, w_mem_req}, 16'd1);
            check($sformatf("wrap%0d_addr", k), w_mem_addr,         wpc);
            tick();
            check($sformatf("wrap%0d_valid", k), {15'd0, w_instr_valid}, 16'd1);
            check($sformatf("wrap%0d_pc", k),    w_instr_pc,             wpc);
            check($sformatf("wrap%0d_instr", k), w_instr,                wpc ^ 16'hA5A5);
            wpc = wpc + 16'd1;
        end
        w_en = 1'b0; w_mem_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
